// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types for the instruction-fetch front end: PC-source
//               encoding from the control unit and the fetch FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Next-PC selection driven by the execute stage; 2'b11 behaves as SEQ.
    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JALR   = 2'b10
    } pcsrc_e;

    // RUN issues and accepts words; FLUSH only drains stale responses.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    // True when the execute stage requests a control-flow change.
    function automatic logic is_redirect(input logic [1:0] pcsrc);
        return (pcsrc == PCSRC_BRANCH) || (pcsrc == PCSRC_JALR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Instruction buffer holding fetched words with their PC.
//               Head entry is presented combinationally together with PC+4.
//               Flush empties the buffer in one cycle and wins over push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
#(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_instr,
    input  logic [ADDR_WIDTH-1:0]   push_pc,
    input  logic                    pop,
    input  logic                    flush,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DATA_WIDTH-1:0]   head_instr,
    output logic [ADDR_WIDTH-1:0]   head_pc,
    output logic [ADDR_WIDTH-1:0]   head_pcplus4
);

    localparam int                    c_ptr_w   = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_pc_step = ADDR_WIDTH'(4);
    localparam logic [c_ptr_w:0]      c_ptr_one = {{c_ptr_w{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem    [DEPTH];
    logic [c_ptr_w:0]      r_wr_ptr;
    logic [c_ptr_w:0]      r_rd_ptr;
    logic                  w_push_en;
    logic                  w_pop_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = r_wr_ptr - r_rd_ptr;
    assign empty     = (count == '0);
    assign w_push_en = push & ~flush;
    assign w_pop_en  = pop & ~flush & ~empty;

    assign head_instr   = r_instr_mem[r_rd_ptr[c_ptr_w-1:0]];
    assign head_pc      = r_pc_mem[r_rd_ptr[c_ptr_w-1:0]];
    assign head_pcplus4 = head_pc + c_pc_step;

    // Read/write pointer update; flush discards every stored entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Entry storage; contents only become visible through the pointers.
    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_instr_mem[r_wr_ptr[c_ptr_w-1:0]] <= push_instr;
            r_pc_mem[r_wr_ptr[c_ptr_w-1:0]]    <= push_pc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end. Owns the fetch PC, issues
//               credit-limited requests to instruction memory, buffers the
//               in-order responses with their PC and hands them to decode.
//               Taken branches/jumps redirect the PC, flush buffered words
//               and drop responses for requests already in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            pcsrc,
    input  logic [ADDR_WIDTH-1:0] pc_ex,
    input  logic [ADDR_WIDTH-1:0] immext,
    input  logic [ADDR_WIDTH-1:0] aluresult,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] instr_pcplus4,
    output logic                  misaligned
);

    localparam int                    c_ptr_w        = $clog2(FIFO_DEPTH);
    localparam int                    c_cnt_w        = c_ptr_w + 1;
    localparam logic [ADDR_WIDTH-1:0] c_pc_step      = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_jalr_mask    = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [ADDR_WIDTH-1:0] c_align_mask   = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [c_cnt_w-1:0]    c_cnt_one      = {{c_ptr_w{1'b0}}, 1'b1};
    localparam logic [c_cnt_w:0]      c_credit_limit = (c_cnt_w+1)'(FIFO_DEPTH);

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_next;
    logic [c_cnt_w-1:0]    r_outstanding;
    logic [c_cnt_w-1:0]    w_outstanding_next;
    logic [c_cnt_w-1:0]    r_drop_cnt;
    logic [c_cnt_w-1:0]    w_drop_next;

    logic [ADDR_WIDTH-1:0] r_pcq_mem [FIFO_DEPTH];
    logic [c_ptr_w:0]      r_pcq_wr;
    logic [c_ptr_w:0]      r_pcq_rd;

    logic                  w_redirect;
    logic                  w_req_valid;
    logic                  w_accept;
    logic                  w_rsp_run;
    logic                  w_fifo_pop;
    logic                  w_fifo_empty;
    logic [c_cnt_w-1:0]    w_fifo_count;
    logic [c_cnt_w:0]      w_credit_used;
    logic [ADDR_WIDTH-1:0] w_target_raw;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_redirect    = is_redirect(pcsrc);
    assign w_accept      = w_req_valid & imem_req_ready;
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};

    // A response always retires one in-flight request, even when discarded.
    assign w_outstanding_next = r_outstanding
                              + (w_accept       ? c_cnt_one : '0)
                              - (imem_rsp_valid ? c_cnt_one : '0);

    // Redirect target; low two bits are dropped, bit 1 reports misalignment.
    always_comb begin
        w_target_raw = aluresult & c_jalr_mask;
        if (pcsrc == PCSRC_BRANCH) begin
            w_target_raw = pc_ex + immext;
        end
    end

    assign w_target   = w_target_raw & c_align_mask;
    assign misaligned = ~rst & w_redirect & w_target_raw[1];

    // Fetch FSM next state, drop counter and request/response gating.
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop_cnt;
        w_req_valid  = 1'b0;
        w_rsp_run    = 1'b0;
        case (r_state)
            RUN: begin
                w_req_valid = ~rst & (w_credit_used < c_credit_limit);
                w_rsp_run   = imem_rsp_valid & ~w_redirect;
                if (w_redirect) begin
                    w_drop_next  = w_outstanding_next;
                    w_state_next = (w_outstanding_next != '0) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if (imem_rsp_valid) begin
                    w_drop_next = r_drop_cnt - c_cnt_one;
                end
                if (w_drop_next == '0) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // Next fetch address: redirect wins over sequential advance.
    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (w_redirect) begin
            w_fetch_pc_next = w_target;
        end else if (w_accept) begin
            w_fetch_pc_next = r_fetch_pc + c_pc_step;
        end
    end

    // State register for the FSM, fetch PC and in-flight counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_outstanding <= w_outstanding_next;
            r_drop_cnt    <= w_drop_next;
        end
    end

    // PC queue pointers: one entry per live request, emptied on redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
        end else if (w_redirect) begin
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
        end else begin
            if (w_accept) begin
                r_pcq_wr <= r_pcq_wr + c_cnt_one;
            end
            if (w_rsp_run) begin
                r_pcq_rd <= r_pcq_rd + c_cnt_one;
            end
        end
    end

    // PC queue storage, written with the address of each accepted request.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pcq_mem[r_pcq_wr[c_ptr_w-1:0]] <= r_fetch_pc;
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc & c_align_mask;

    assign w_fifo_pop  = instr_valid & instr_ready & ~w_redirect;
    assign instr_valid = ~w_fifo_empty & (r_state == RUN);

    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fetch_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (w_rsp_run),
        .push_instr   (imem_rsp_data),
        .push_pc      (r_pcq_mem[r_pcq_rd[c_ptr_w-1:0]]),
        .pop          (w_fifo_pop),
        .flush        (w_redirect),
        .empty        (w_fifo_empty),
        .count        (w_fifo_count),
        .head_instr   (instr),
        .head_pc      (instr_pc),
        .head_pcplus4 (instr_pcplus4)
    );

endmodule
`default_nettype wire
